issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Issue-stage controller for the Tomasulo core. It accepts one decoded instruction per cycle from decode and allocates the next ROB tag. It checks reservation-station availability per functional class and drives the register status table's write port (issue_writes / issue_dest / issue_ROB). On a committed mispredict it runs a flush sequence that clears the register status table and rewinds tag allocation.

## Interface
Parameters:
- ROB_TAGS, 15: usable ROB tags, numbered 1..15; tag 0 is reserved to mean "operand ready" in the register status table.
- N_CLASS, 4: reservation-station classes: ALU=0, LOAD=1, STORE=2, BRANCH=3.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- inst_valid  in  1  decode holds a valid instruction.
- inst_class  in  2  functional class of the instruction (inst_class_t).
- inst_rd  in  5  destination register.
- inst_writes_rd  in  1  instruction writes rd (0 for store, branch).
- rs_free  in  N_CLASS  per-class "reservation station has a free slot".
- commit_valid  in  1  ROB head retires this cycle.
- mispredict  in  1  retiring instruction is a mispredicted branch; only valid with commit_valid.
- inst_ready  out  1  issue accepted this cycle (decode handshake).
- rs_alloc  out  N_CLASS  one-hot allocate strobe to the selected reservation station.
- issue_writes  out  1  to regstat: mark issue_dest busy.
- issue_dest  out  5  to regstat: inst_rd passthrough.
- issue_ROB  out  4  tag assigned to the issuing instruction.
- regstat_flush  out  1  clear pulse ORed into the register status table reset.
- rob_count  out  4  in-flight instruction count, 0..15.

## Operation
- State machine issue_state_t has two states:
  - RUN → FLUSH when commit_valid & mispredict.
  - FLUSH → RUN unconditionally after one cycle.
- Reset values: state RUN; tail_tag 1; head_tag 1; rob_count 0; all outputs 0, except issue_ROB = 1.
- Issue fires when state==RUN & inst_valid & rs_free[inst_class] & rob_count!=15 & !(commit_valid & mispredict).
- When issue fires:
  - inst_ready=1 and rs_alloc[inst_class]=1.
  - issue_writes = inst_writes_rd & (inst_rd!=0).
  - tail_tag advances.
- When issue does not fire, inst_ready, rs_alloc and issue_writes are all 0. Decode must hold its inputs stable until inst_ready.
- Tag wrap: 15 → 1, never producing 0. head_tag follows the same rule on every commit.
- Count update:
  - +1 on issue only; −1 on commit only; unchanged on issue and commit together.
  - A commit with rob_count==0 is ignored; the bench flags it as an assertion.
- Full: rob_count==15 blocks issue even when a commit occurs that same cycle. There is no same-cycle bypass.
- Mispredict commit: the next edge enters FLUSH and sets head_tag=tail_tag=1 and rob_count=0.
- In FLUSH: regstat_flush=1 and no issue. RUN resumes the following cycle with issue_ROB=1.
- A reset asserted during FLUSH returns to the RUN reset state.

## Timing
- Issue decision is combinational from inputs and registered state, giving zero-cycle handshake latency. issue_ROB is a register (tail_tag).
- Pointers, count and state update on the rising clk edge after the event.
- regstat_flush is high for exactly one cycle, the cycle after the mispredict commit.
- Minimum mispredict-to-next-issue is 2 cycles.
- There is no combinational path from commit_valid to inst_ready except through the mispredict term.

## Structure
- Add to structs.svh:
  - inst_class_t enum.
  - issue_state_t enum {RUN, FLUSH}.
  - localparams ROB_TAG_W=4, ROB_LAST_TAG=15, ROB_FIRST_TAG=1.
- One sub-module, rob_tag_counter: 4-bit register with synchronous reset to 1, an advance enable, a load-to-1 input, and wrap 15→1. It is instantiated twice, for head and tail.
- The count register and FSM live in issue_ctrl.

## Test plan
- Reset, then 3 ALU issues to rd=5, 6, 7 with rs_free=4'b1111 → issue_ROB 1, 2, 3; issue_writes=1 each; rs_alloc=4'b0001; rob_count=3.
- Issue 15 instructions with no commits → rob_count=15 and inst_ready=0 on the 16th. A commit in that same cycle still blocks; the next cycle issues with tag 1 (wrap past 0).
- STORE issue, then ALU issue with rd=0 → issue_writes=0 both times, tags still allocated, rs_alloc=4'b0100 then 4'b0001.
- rs_free=4'b1110 with an ALU instruction held 3 cycles → inst_ready=0 for 3 cycles. Set rs_free[0]=1 → issues with the next tag.
- After 4 in flight, commit_valid with mispredict → next cycle regstat_flush=1, rob_count=0, no issue. The cycle after that issues with issue_ROB=1.
- Simultaneous issue and commit at rob_count=7 → rob_count stays 7; tail and head both advance.

Source files
------------

// File: rtl/issue_ctrl_pkg.sv
// Shared types, widths and tag arithmetic for the issue stage.
package issue_ctrl_pkg;

  localparam int unsigned ROB_TAG_W     = 4;
  localparam int unsigned ROB_LAST_TAG  = 15;
  localparam int unsigned ROB_FIRST_TAG = 1;
  localparam int unsigned CLASS_W       = 2;
  localparam int unsigned REG_W         = 5;

  typedef enum logic [CLASS_W-1:0] {
    CLASS_ALU    = 2'd0,
    CLASS_LOAD   = 2'd1,
    CLASS_STORE  = 2'd2,
    CLASS_BRANCH = 2'd3
  } inst_class_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } issue_state_t;

  // Tag 0 means "operand ready" in regstat, so the sequence skips it.
  function automatic logic [ROB_TAG_W-1:0] next_tag(input logic [ROB_TAG_W-1:0] tag);
    if (tag == ROB_TAG_W'(ROB_LAST_TAG)) begin
      return ROB_TAG_W'(ROB_FIRST_TAG);
    end
    return tag + ROB_TAG_W'(1);
  endfunction

endpackage

// File: rtl/issue_ctrl_rob_tag_counter.sv
// ROB tag pointer: resets or loads to the first tag, advances with 15->1 wrap.
module rob_tag_counter
  import issue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  input  logic                 load_first,
  output logic [ROB_TAG_W-1:0] tag
);

  always_ff @(posedge clk) begin
    if (reset || load_first) begin
      tag <= ROB_TAG_W'(ROB_FIRST_TAG);
    end else if (advance) begin
      tag <= next_tag(tag);
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue-stage controller: ROB tag allocation, RS availability check,
// regstat write port, and the one-cycle flush after a committed mispredict.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned ROB_TAGS = 15,
  parameter int unsigned N_CLASS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_valid,
  input  logic [CLASS_W-1:0]   inst_class,
  input  logic [REG_W-1:0]     inst_rd,
  input  logic                 inst_writes_rd,
  input  logic [N_CLASS-1:0]   rs_free,
  input  logic                 commit_valid,
  input  logic                 mispredict,
  output logic                 inst_ready,
  output logic [N_CLASS-1:0]   rs_alloc,
  output logic                 issue_writes,
  output logic [REG_W-1:0]     issue_dest,
  output logic [ROB_TAG_W-1:0] issue_ROB,
  output logic                 regstat_flush,
  output logic [ROB_TAG_W-1:0] rob_count
);

  issue_state_t         state;
  issue_state_t         state_nxt;
  logic                 flush_req;
  logic                 commit_ok;
  logic                 rob_full;
  logic                 issue_fire;
  logic [ROB_TAG_W-1:0] head_tag;
  logic                 unused_head;

  assign flush_req  = (state == RUN) && commit_valid && mispredict;
  // A commit against an empty ROB is a protocol error and is dropped.
  assign commit_ok  = (state == RUN) && commit_valid && (rob_count != '0);
  assign rob_full   = (rob_count == ROB_TAG_W'(ROB_TAGS));
  assign issue_fire = !reset && (state == RUN) && inst_valid && rs_free[inst_class]
                      && !rob_full && !flush_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    inst_ready   = 1'b0;
    rs_alloc     = '0;
    issue_writes = 1'b0;
    issue_dest   = '0;
    case (state)
      RUN:     if (flush_req) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (issue_fire) begin
      inst_ready           = 1'b1;
      rs_alloc[inst_class] = 1'b1;
      issue_writes         = inst_writes_rd && (inst_rd != '0);
      issue_dest           = inst_rd;
    end
  end

  assign regstat_flush = (state == FLUSH);

  // In-flight count; flush wins over any concurrent issue/commit.
  always_ff @(posedge clk) begin
    if (reset || flush_req) begin
      rob_count <= '0;
    end else if (issue_fire && !commit_ok) begin
      rob_count <= rob_count + ROB_TAG_W'(1);
    end else if (commit_ok && !issue_fire) begin
      rob_count <= rob_count - ROB_TAG_W'(1);
    end
  end

  rob_tag_counter u_tail (
    .clk        (clk),
    .reset      (reset),
    .advance    (issue_fire),
    .load_first (flush_req),
    .tag        (issue_ROB)
  );

  rob_tag_counter u_head (
    .clk        (clk),
    .reset      (reset),
    .advance    (commit_ok),
    .load_first (flush_req),
    .tag        (head_tag)
  );

  // Head pointer is tracked for the ROB side; not exported on this block.
  assign unused_head = ^head_tag;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl with a queue scoreboard checked by a monitor.
module tb_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       inst_valid;
  logic [1:0] inst_class;
  logic [4:0] inst_rd;
  logic       inst_writes_rd;
  logic [3:0] rs_free;
  logic       commit_valid;
  logic       mispredict;
  logic       inst_ready;
  logic [3:0] rs_alloc;
  logic       issue_writes;
  logic [4:0] issue_dest;
  logic [3:0] issue_ROB;
  logic       regstat_flush;
  logic [3:0] rob_count;

  typedef struct packed {
    logic [3:0] tag;
    logic       writes;
    logic [4:0] dest;
    logic [3:0] alloc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  issue_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .inst_valid     (inst_valid),
    .inst_class     (inst_class),
    .inst_rd        (inst_rd),
    .inst_writes_rd (inst_writes_rd),
    .rs_free        (rs_free),
    .commit_valid   (commit_valid),
    .mispredict     (mispredict),
    .inst_ready     (inst_ready),
    .rs_alloc       (rs_alloc),
    .issue_writes   (issue_writes),
    .issue_dest     (issue_dest),
    .issue_ROB      (issue_ROB),
    .regstat_flush  (regstat_flush),
    .rob_count      (rob_count)
  );

  // Monitor: every accepted issue must match the oldest expected transaction.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (inst_ready) begin
      total++;
      a = '{tag: issue_ROB, writes: issue_writes, dest: issue_dest, alloc: rs_alloc};
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got tag=%0d writes=%0b dest=%0d alloc=%b, expected none",
                 issue_ROB, issue_writes, issue_dest, rs_alloc);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL issue_txn: got tag=%0d writes=%0b dest=%0d alloc=%b, expected tag=%0d writes=%0b dest=%0d alloc=%b",
                   a.tag, a.writes, a.dest, a.alloc, e.tag, e.writes, e.dest, e.alloc);
        end
      end
    end
    if (commit_valid && !reset) begin
      total++;
      if (rob_count == 4'd0) begin
        bad++;
        $display("FAIL commit_empty: commit with rob_count=%0d, expected nonzero", rob_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] cls, input logic [4:0] rd,
                        input logic wr, input logic [3:0] free, input logic cv, input logic mp);
    inst_valid     = v;
    inst_class     = cls;
    inst_rd        = rd;
    inst_writes_rd = wr;
    rs_free        = free;
    commit_valid   = cv;
    mispredict     = mp;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 2'd0, 5'd0, 1'b0, 4'hF, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next_drive();
    @(negedge clk);
    chk("rst_issue_ROB", issue_ROB, 1);
    chk("rst_rob_count", rob_count, 0);
    chk("rst_inst_ready", inst_ready, 0);
    chk("rst_rs_alloc", rs_alloc, 0);
    chk("rst_issue_writes", issue_writes, 0);
    chk("rst_issue_dest", issue_dest, 0);
    chk("rst_flush", regstat_flush, 0);
    next_drive();
    reset = 1'b0;
  endtask

  // One issue attempt that must be accepted this cycle.
  task automatic issue(input logic [1:0] cls, input logic [4:0] rd, input logic wr,
                       input logic [3:0] tag, input logic exp_wr);
    exp_t e;
    set_in(1'b1, cls, rd, wr, 4'hF, 1'b0, 1'b0);
    e = '{tag: tag, writes: exp_wr, dest: rd, alloc: 4'(1 << cls)};
    sb.push_back(e);
    @(negedge clk);
    chk("issue_ready", inst_ready, 1);
    next_drive();
    idle();
  endtask

  task automatic check_count(input string name, input int exp);
    idle();
    @(negedge clk);
    chk(name, rob_count, exp);
    next_drive();
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    idle();

    // Three ALU issues
    do_reset();
    issue(2'd0, 5'd5, 1'b1, 4'd1, 1'b1);
    issue(2'd0, 5'd6, 1'b1, 4'd2, 1'b1);
    issue(2'd0, 5'd7, 1'b1, 4'd3, 1'b1);
    check_count("count_after_3", 3);

    // Fill to 15, block with a same-cycle commit, then issue tag 1
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      issue(2'd0, 5'(i), 1'b1, 4'(i), 1'b1);
    end
    set_in(1'b1, 2'd0, 5'd9, 1'b1, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_blocks_ready", inst_ready, 0);
    chk("full_count", rob_count, 15);
    next_drive();
    commit_valid = 1'b0;
    e = '{tag: 4'd1, writes: 1'b1, dest: 5'd9, alloc: 4'b0001};
    sb.push_back(e);
    @(negedge clk);
    chk("wrap_ready", inst_ready, 1);
    chk("count_after_commit", rob_count, 14);
    next_drive();
    check_count("count_refilled", 15);

    // Store and rd=0 never write regstat
    do_reset();
    issue(2'd2, 5'd3, 1'b0, 4'd1, 1'b0);
    issue(2'd0, 5'd0, 1'b1, 4'd2, 1'b0);

    // ALU station busy for three cycles, then free
    set_in(1'b1, 2'd0, 5'd12, 1'b1, 4'b1110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_busy_ready", inst_ready, 0);
      chk("rs_busy_alloc", rs_alloc, 0);
      next_drive();
    end
    rs_free = 4'b1111;
    e = '{tag: 4'd3, writes: 1'b1, dest: 5'd12, alloc: 4'b0001};
    sb.push_back(e);
    @(negedge clk);
    chk("rs_freed_ready", inst_ready, 1);
    next_drive();
    check_count("count_after_rs", 3);

    // Mispredict with four in flight
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue(2'd1, 5'(i + 10), 1'b1, 4'(i), 1'b1);
    end
    set_in(1'b1, 2'd0, 5'd8, 1'b1, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    chk("mispredict_blocks", inst_ready, 0);
    chk("flush_not_yet", regstat_flush, 0);
    next_drive();
    commit_valid = 1'b0;
    mispredict   = 1'b0;
    @(negedge clk);
    chk("flush_pulse", regstat_flush, 1);
    chk("flush_count", rob_count, 0);
    chk("flush_no_issue", inst_ready, 0);
    chk("flush_tag", issue_ROB, 1);
    next_drive();
    e = '{tag: 4'd1, writes: 1'b1, dest: 5'd8, alloc: 4'b0001};
    sb.push_back(e);
    @(negedge clk);
    chk("post_flush_ready", inst_ready, 1);
    chk("flush_one_cycle", regstat_flush, 0);
    next_drive();
    check_count("post_flush_count", 1);

    // Simultaneous issue and commit at count 7
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      issue(2'd3, 5'd0, 1'b0, 4'(i), 1'b0);
    end
    set_in(1'b1, 2'd0, 5'd20, 1'b1, 4'hF, 1'b1, 1'b0);
    e = '{tag: 4'd8, writes: 1'b1, dest: 5'd20, alloc: 4'b0001};
    sb.push_back(e);
    @(negedge clk);
    chk("both_ready", inst_ready, 1);
    next_drive();
    idle();
    @(negedge clk);
    chk("both_count", rob_count, 7);
    chk("both_tail", issue_ROB, 9);
    next_drive();

    // Reset asserted while in FLUSH
    set_in(1'b0, 2'd0, 5'd0, 1'b0, 4'hF, 1'b1, 1'b1);
    next_drive();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("flush_before_reset", regstat_flush, 1);
    next_drive();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_flush_flush", regstat_flush, 0);
    chk("reset_in_flush_tag", issue_ROB, 1);
    chk("reset_in_flush_count", rob_count, 0);
    next_drive();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
